// File: rtl/sram_bus_arbiter.sv
// Two-master round-robin arbiter in front of the 68000-style SRAM/boot bus.
// Define ARB_TIMEOUT_EN to add the no-ack timeout that raises berr on the granted master.
module sram_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] m0_addr,
  input  logic [15:0] m0_data_write,
  output logic [15:0] m0_data_read,
  input  logic        m0_uds,
  input  logic        m0_lds,
  input  logic        m0_rw,
  output logic        m0_ack,
  output logic        m0_berr,
  input  logic [23:0] m1_addr,
  input  logic [15:0] m1_data_write,
  output logic [15:0] m1_data_read,
  input  logic        m1_uds,
  input  logic        m1_lds,
  input  logic        m1_rw,
  output logic        m1_ack,
  output logic        m1_berr,
  output logic [23:0] s_addr,
  output logic [15:0] s_data_write,
  output logic        s_uds,
  output logic        s_lds,
  output logic        s_rw,
  input  logic [15:0] s_data_read,
  input  logic        s_ack,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   w_last_next;
  logic   w_req0;
  logic   w_req1;
  logic   w_granted;
  logic   w_timeout;

  if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_cfg_check
    $error("CNT_W too narrow to count TIMEOUT_CYCLES");
  end

  assign w_req0    = m0_uds | m0_lds;
  assign w_req1    = m1_uds | m1_lds;
  assign w_granted = (r_state == GRANT0) || (r_state == GRANT1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
    end
  end

  // Arbitration on the live strobes; a tie goes to the master not granted last.
  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    case (r_state)
      IDLE, RELEASE: begin
        if (w_req0 && w_req1) w_next = r_last ? GRANT0 : GRANT1;
        else if (w_req0)      w_next = GRANT0;
        else if (w_req1)      w_next = GRANT1;
        else                  w_next = IDLE;
      end
      GRANT0: begin
        if (!w_req0) begin
          w_next      = RELEASE;
          w_last_next = 1'b0;
        end
      end
      GRANT1: begin
        if (!w_req1) begin
          w_next      = RELEASE;
          w_last_next = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_acked;

  // Counter stops on the first ack or at the limit, and restarts on every new grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_acked <= 1'b0;
    end else if (!w_granted) begin
      r_cnt   <= '0;
      r_acked <= 1'b0;
    end else if (s_ack) begin
      r_acked <= 1'b1;
    end else if (!r_acked && (r_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = w_granted && (r_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    gnt          = 2'b00;
    s_addr       = '0;
    s_data_write = '0;
    s_uds        = 1'b0;
    s_lds        = 1'b0;
    s_rw         = 1'b1;
    m0_ack       = 1'b0;
    m1_ack       = 1'b0;
    m0_data_read = '0;
    m1_data_read = '0;
    m0_berr      = 1'b0;
    m1_berr      = 1'b0;
    case (r_state)
      GRANT0: begin
        gnt          = 2'b01;
        s_addr       = m0_addr;
        s_data_write = m0_data_write;
        s_rw         = m0_rw;
        s_uds        = m0_uds & ~w_timeout;
        s_lds        = m0_lds & ~w_timeout;
        m0_ack       = s_ack;
        m0_data_read = s_data_read;
        m0_berr      = w_timeout;
      end
      GRANT1: begin
        gnt          = 2'b10;
        s_addr       = m1_addr;
        s_data_write = m1_data_write;
        s_rw         = m1_rw;
        s_uds        = m1_uds & ~w_timeout;
        s_lds        = m1_lds & ~w_timeout;
        m1_ack       = s_ack;
        m1_data_read = s_data_read;
        m1_berr      = w_timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios then random traffic against an owner/last reference model.
module tb_sram_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] m0_addr, m1_addr, s_addr;
  logic [15:0] m0_data_write, m1_data_write, s_data_write;
  logic [15:0] m0_data_read, m1_data_read, s_data_read;
  logic        m0_uds, m0_lds, m0_rw, m0_ack, m0_berr;
  logic        m1_uds, m1_lds, m1_rw, m1_ack, m1_berr;
  logic        s_uds, s_lds, s_rw, s_ack;
  logic [1:0]  gnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the bus (0 none, 1 master0, 2 master1) and who was granted last.
  int m_owner;
  bit m_last;
  int m_cnt;
  bit m_acked;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_data_write(m0_data_write), .m0_data_read(m0_data_read),
    .m0_uds(m0_uds), .m0_lds(m0_lds), .m0_rw(m0_rw), .m0_ack(m0_ack), .m0_berr(m0_berr),
    .m1_addr(m1_addr), .m1_data_write(m1_data_write), .m1_data_read(m1_data_read),
    .m1_uds(m1_uds), .m1_lds(m1_lds), .m1_rw(m1_rw), .m1_ack(m1_ack), .m1_berr(m1_berr),
    .s_addr(s_addr), .s_data_write(s_data_write), .s_uds(s_uds), .s_lds(s_lds), .s_rw(s_rw),
    .s_data_read(s_data_read), .s_ack(s_ack), .gnt(gnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 1'b1;
    m_cnt   = 0;
    m_acked = 1'b0;
  endtask

  task automatic model_edge();
    bit r0, r1;
    if (!reset_n) return;
    r0 = m0_uds | m0_lds;
    r1 = m1_uds | m1_lds;
    if (m_owner != 0) begin
      if (s_ack) m_acked = 1'b1;
      else if (!m_acked && m_cnt < TO) m_cnt++;
    end
    if (m_owner == 1) begin
      if (!r0) begin m_owner = 0; m_last = 1'b0; end
    end else if (m_owner == 2) begin
      if (!r1) begin m_owner = 0; m_last = 1'b1; end
    end else begin
      if (r0 && r1)  m_owner = m_last ? 1 : 2;
      else if (r0)   m_owner = 1;
      else if (r1)   m_owner = 2;
      if (m_owner != 0) begin m_cnt = 0; m_acked = 1'b0; end
    end
  endtask

  task automatic check_all();
    logic [1:0] eg; logic [23:0] ea; logic [15:0] ed, er0, er1;
    logic eu, el, erw, ek0, ek1, eb0, eb1, to;
    to = 1'b0;
`ifdef ARB_TIMEOUT_EN
    to = (m_owner != 0) && (m_cnt >= TO);
`endif
    eg = 2'b00; ea = '0; ed = '0; eu = 0; el = 0; erw = 1;
    ek0 = 0; ek1 = 0; er0 = '0; er1 = '0; eb0 = 0; eb1 = 0;
    if (m_owner == 1) begin
      eg = 2'b01; ea = m0_addr; ed = m0_data_write; erw = m0_rw;
      eu = m0_uds & ~to; el = m0_lds & ~to; ek0 = s_ack; er0 = s_data_read; eb0 = to;
    end else if (m_owner == 2) begin
      eg = 2'b10; ea = m1_addr; ed = m1_data_write; erw = m1_rw;
      eu = m1_uds & ~to; el = m1_lds & ~to; ek1 = s_ack; er1 = s_data_read; eb1 = to;
    end
    chk("gnt", gnt, eg);
    chk("s_addr", s_addr, ea);
    chk("s_data_write", s_data_write, ed);
    chk("s_uds", s_uds, eu);
    chk("s_lds", s_lds, el);
    chk("s_rw", s_rw, erw);
    chk("m0_ack", m0_ack, ek0);
    chk("m1_ack", m1_ack, ek1);
    chk("m0_data_read", m0_data_read, er0);
    chk("m1_data_read", m1_data_read, er1);
    chk("m0_berr", m0_berr, eb0);
    chk("m1_berr", m1_berr, eb1);
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge, return just after it.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_m0(input logic u, input logic l, input logic rw, input logic [23:0] a, input logic [15:0] d);
    m0_uds = u; m0_lds = l; m0_rw = rw; m0_addr = a; m0_data_write = d;
  endtask

  task automatic set_m1(input logic u, input logic l, input logic rw, input logic [23:0] a, input logic [15:0] d);
    m1_uds = u; m1_lds = l; m1_rw = rw; m1_addr = a; m1_data_write = d;
  endtask

  initial begin
    int order[$];
    int h0, h1, hold0, hold1;
    logic [1:0] prev_gnt;

    reset_n = 1'b0;
    set_m0(0, 0, 1, '0, '0);
    set_m1(0, 0, 1, '0, '0);
    s_ack = 1'b0; s_data_read = '0;
    model_reset();
    #3;
    chk("reset_gnt", gnt, 2'b00);
    chk("reset_s_rw", s_rw, 1'b1);
    chk("reset_s_uds", s_uds, 1'b0);
    chk("reset_m0_berr", m0_berr, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Single m0 read; ack forwarded combinationally.
    set_m0(1, 1, 1, 24'h001000, 16'h0);
    cycle();
    chk("single_gnt", gnt, 2'b01);
    chk("single_s_addr", s_addr, 24'h001000);
    chk("single_s_rw", s_rw, 1'b1);
    s_ack = 1'b1; s_data_read = 16'hBEEF;
    #1;
    chk("single_m0_ack", m0_ack, 1'b1);
    chk("single_m1_ack", m1_ack, 1'b0);
    chk("single_m0_rd", m0_data_read, 16'hBEEF);
    cycle();
    s_ack = 1'b0;
    set_m0(0, 0, 1, 24'h001000, 16'h0);
    cycle();
    chk("single_release_gnt", gnt, 2'b00);
    cycle();

    // Simultaneous requests right after reset: m0 first, one-cycle gap, then m1.
    reset_n = 1'b0; model_reset();
    #1; reset_n = 1'b1;
    set_m0(1, 1, 0, 24'h002000, 16'h1234);
    set_m1(1, 0, 1, 24'h003000, 16'h0);
    cycle();
    chk("tie_first_gnt", gnt, 2'b01);
    chk("tie_first_rw", s_rw, 1'b0);
    cycle();
    set_m0(0, 0, 1, 24'h002000, 16'h1234);
    cycle();
    chk("tie_gap_gnt", gnt, 2'b00);
    chk("tie_gap_uds", s_uds, 1'b0);
    cycle();
    chk("tie_second_gnt", gnt, 2'b10);
    chk("tie_second_addr", s_addr, 24'h003000);
    set_m1(0, 0, 1, 24'h003000, 16'h0);
    cycle(); cycle();

    // Continuous requests from both masters: grants must alternate.
    h0 = 0; h1 = 0; prev_gnt = 2'b00;
    set_m0(1, 1, 1, 24'h004000, 16'h0);
    set_m1(1, 1, 1, 24'h005000, 16'h0);
    for (int i = 0; i < 80 && order.size() < 6; i++) begin
      cycle();
      if (gnt != 2'b00 && prev_gnt == 2'b00) order.push_back(gnt == 2'b01 ? 0 : 1);
      prev_gnt = gnt;
      if (!m0_uds) begin m0_uds = 1; m0_lds = 1; end
      else if (gnt[0]) begin h0++; if (h0 >= 2) begin m0_uds = 0; m0_lds = 0; h0 = 0; end end
      if (!m1_uds) begin m1_uds = 1; m1_lds = 1; end
      else if (gnt[1]) begin h1++; if (h1 >= 2) begin m1_uds = 0; m1_lds = 0; h1 = 0; end end
    end
    chk("fair_count", order.size(), 6);
    for (int i = 0; i < order.size(); i++) chk("fair_order", order[i], i % 2);
    set_m0(0, 0, 1, '0, '0);
    set_m1(0, 0, 1, '0, '0);
    repeat (3) cycle();

    // m1 aborts before any ack.
    set_m1(1, 1, 1, 24'h006000, 16'h0);
    cycle();
    chk("abort_gnt", gnt, 2'b10);
    chk("abort_ack_granted", m1_ack, 1'b0);
    set_m1(0, 0, 1, 24'h006000, 16'h0);
    cycle();
    chk("abort_release_gnt", gnt, 2'b00);
    cycle();
    chk("abort_idle_gnt", gnt, 2'b00);
    chk("abort_idle_ack", m1_ack, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Slave never acks: berr after TO grant cycles, strobes forced low the same cycle.
    set_m0(1, 1, 1, 24'h007000, 16'h0);
    cycle();
    chk("to_first_uds", s_uds, 1'b1);
    set_m1(1, 1, 1, 24'h008000, 16'h0);
    for (int i = 1; i < TO; i++) begin
      cycle();
      chk("to_pre_berr", m0_berr, 1'b0);
    end
    cycle();
    chk("to_berr", m0_berr, 1'b1);
    chk("to_uds_forced", s_uds, 1'b0);
    chk("to_other_berr", m1_berr, 1'b0);
    cycle();
    set_m0(0, 0, 1, 24'h007000, 16'h0);
    cycle();
    chk("to_release_gnt", gnt, 2'b00);
    cycle();
    chk("to_next_gnt", gnt, 2'b10);
    chk("to_next_uds", s_uds, 1'b1);
    set_m1(0, 0, 1, '0, '0);
    repeat (2) cycle();
`else
    // Without the timeout the grant is held indefinitely.
    set_m0(1, 1, 1, 24'h007000, 16'h0);
    repeat (1100) cycle();
    chk("hold_gnt", gnt, 2'b01);
    chk("hold_berr", m0_berr, 1'b0);
    set_m0(0, 0, 1, '0, '0);
    repeat (2) cycle();
`endif

    // Asynchronous reset in the middle of a write.
    set_m0(1, 1, 0, 24'h009000, 16'h5555);
    cycle();
    chk("rst_write_gnt", gnt, 2'b01);
    chk("rst_write_rw", s_rw, 1'b0);
    #2;
    reset_n = 1'b0; model_reset();
    #1;
    chk("rst_async_uds", s_uds, 1'b0);
    chk("rst_async_lds", s_lds, 1'b0);
    chk("rst_async_gnt", gnt, 2'b00);
    chk("rst_async_rw", s_rw, 1'b1);
    cycle();
    reset_n = 1'b1;
    cycle();
    chk("rst_regrant_gnt", gnt, 2'b01);
    set_m0(0, 0, 1, '0, '0);
    repeat (2) cycle();

    // Random traffic from both masters and a random slave.
    hold0 = 0; hold1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold0 == 0) begin
        set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               24'($urandom), 16'($urandom));
        hold0 = $urandom_range(1, 6);
      end
      if (hold1 == 0) begin
        set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               24'($urandom), 16'($urandom));
        hold1 = $urandom_range(1, 6);
      end
      hold0--; hold1--;
      s_ack = ($urandom_range(0, 3) == 0);
      s_data_read = 16'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
